// File: rtl/cpu_useq_pkg.sv
// rtl/cpu_useq_pkg.sv - shared command/error encodings for the micro-sequencer
package cpu_useq_pkg;

    typedef enum logic [1:0] {
        CMD_NEXT = 2'd0,
        CMD_CALL = 2'd1,
        CMD_RET  = 2'd2,
        CMD_WAIT = 2'd3
    } useq_cmd_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_OVF  = 2'd1,
        ERR_UNF  = 2'd2,
        ERR_TMO  = 2'd3
    } useq_err_t;

endpackage

// File: rtl/cpu_useq_stack.sv
// rtl/cpu_useq_stack.sv - return-address LIFO with level counter, full/empty and top-of-stack read
module cpu_useq_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr,
    input  logic                             push,
    input  logic                             pop,
    input  logic [WIDTH-1:0]                 push_data,
    output logic [WIDTH-1:0]                 top_data,
    output logic [$clog2(DEPTH+1)-1:0]       level,
    output logic                             full,
    output logic                             empty
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [0:(1 << AW) - 1];
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign wr_idx   = AW'(level);
    assign rd_idx   = AW'(level - 1'b1);
    assign top_data = mem[rd_idx];
    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else if (clr) begin
            level <= '0;
        end else if (push) begin
            level <= level + 1'b1;
        end else if (pop) begin
            level <= level - 1'b1;
        end
    end

    // Storage is deliberately left unreset; only entries below level are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/cpu_useq.sv
// rtl/cpu_useq.sv - micro-sequencer with return stack, sticky fault latch and
// optional wait watchdog (USEQ_WATCHDOG_EN)
module cpu_useq
    import cpu_useq_pkg::*;
#(
    parameter int          STATE_WIDTH = 8,
    parameter int          STACK_DEPTH = 8,
    parameter int unsigned RESET_STATE = 0,
    parameter int unsigned FAULT_STATE = 'hFF,
    parameter int          WDOG_CYCLES = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [1:0]                           cmd,
    input  logic [STATE_WIDTH-1:0]               tgt_state,
    input  logic [STATE_WIDTH-1:0]               ret_state,
    input  logic                                 ready,
    input  logic                                 clr_fault,
    output logic [STATE_WIDTH-1:0]               state,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     stack_level,
    output logic                                 fault,
    output logic [1:0]                           err_code
);
    localparam logic [STATE_WIDTH-1:0] RST_S = STATE_WIDTH'(RESET_STATE);
    localparam logic [STATE_WIDTH-1:0] FLT_S = STATE_WIDTH'(FAULT_STATE);

    useq_cmd_t              cmd_e;
    useq_err_t              err_q;
    logic                   live;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic                   wdog_hit;
    logic [STATE_WIDTH-1:0] top_data;

    assign cmd_e    = useq_cmd_t'(cmd);
    assign live     = !clr_fault && !fault;
    assign push     = live && (cmd_e == CMD_CALL) && !full;
    assign pop      = live && (cmd_e == CMD_RET) && !empty;
    assign err_code = err_q;

    cpu_useq_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (STATE_WIDTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr_fault),
        .push      (push),
        .pop       (pop),
        .push_data (ret_state),
        .top_data  (top_data),
        .level     (stack_level),
        .full      (full),
        .empty     (empty)
    );

`ifdef USEQ_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wdog_cnt;
    logic          wait_stall;

    // The limit cycle itself raises the fault, so compare against WDOG_CYCLES-1 prior stalls.
    assign wait_stall = live && (cmd_e == CMD_WAIT) && !ready;
    assign wdog_hit   = wait_stall && (wdog_cnt == WW'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt <= '0;
        end else if (wait_stall && !wdog_hit) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end else begin
            wdog_cnt <= '0;
        end
    end
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG_CYCLES != 0);
    assign wdog_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_S;
            fault <= 1'b0;
            err_q <= ERR_NONE;
        end else if (clr_fault) begin
            state <= RST_S;
            fault <= 1'b0;
            err_q <= ERR_NONE;
        end else if (fault) begin
            state <= FLT_S;
        end else begin
            case (cmd_e)
                CMD_NEXT: state <= tgt_state;
                CMD_CALL: begin
                    if (full) begin
                        state <= FLT_S;
                        fault <= 1'b1;
                        err_q <= ERR_OVF;
                    end else begin
                        state <= tgt_state;
                    end
                end
                CMD_RET: begin
                    if (empty) begin
                        state <= FLT_S;
                        fault <= 1'b1;
                        err_q <= ERR_UNF;
                    end else begin
                        state <= top_data;
                    end
                end
                CMD_WAIT: begin
                    if (ready) begin
                        state <= tgt_state;
                    end else if (wdog_hit) begin
                        state <= FLT_S;
                        fault <= 1'b1;
                        err_q <= ERR_TMO;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_useq.sv
// tb/tb_cpu_useq.sv - directed plus randomized checks of cpu_useq against a queue-based model
module tb_cpu_useq;
    import cpu_useq_pkg::*;

    localparam int SW    = 8;
    localparam int DEPTH = 4;
    localparam int WDOG  = 16;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic [1:0]    cmd;
    logic [SW-1:0] tgt_state;
    logic [SW-1:0] ret_state;
    logic          ready;
    logic          clr_fault;
    logic [SW-1:0] state;
    logic [LW-1:0] stack_level;
    logic          fault;
    logic [1:0]    err_code;

    cpu_useq #(
        .STATE_WIDTH (SW),
        .STACK_DEPTH (DEPTH),
        .RESET_STATE (0),
        .FAULT_STATE ('hFF),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (cmd),
        .tgt_state   (tgt_state),
        .ret_state   (ret_state),
        .ready       (ready),
        .clr_fault   (clr_fault),
        .state       (state),
        .stack_level (stack_level),
        .fault       (fault),
        .err_code    (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [SW-1:0] m_state;
    logic [SW-1:0] m_stk [$];
    logic          m_fault;
    logic [1:0]    m_err;
    int            m_wait;
    int            checks;
    int            failures;

    task automatic model_reset();
        m_state = 8'h00;
        m_stk.delete();
        m_fault = 1'b0;
        m_err   = 2'd0;
        m_wait  = 0;
    endtask

    task automatic model_raise(input logic [1:0] code);
        m_fault = 1'b1;
        m_state = 8'hFF;
        m_err   = code;
    endtask

    task automatic model_step(input logic [1:0] c, input logic [SW-1:0] t, input logic [SW-1:0] r,
                              input logic rdy, input logic clr);
        bit stalled;
        stalled = 1'b0;
        if (clr) begin
            model_reset();
        end else if (m_fault) begin
            m_state = 8'hFF;
        end else begin
            case (c)
                2'd0: m_state = t;
                2'd1: begin
                    if (m_stk.size() < DEPTH) begin
                        m_stk.push_back(r);
                        m_state = t;
                    end else begin
                        model_raise(2'd1);
                    end
                end
                2'd2: begin
                    if (m_stk.size() > 0) m_state = m_stk.pop_back();
                    else model_raise(2'd2);
                end
                default: begin
                    if (rdy) begin
                        m_state = t;
                    end else begin
                        stalled = 1'b1;
`ifdef USEQ_WATCHDOG_EN
                        if (m_wait + 1 == WDOG) begin
                            model_raise(2'd3);
                            stalled = 1'b0;
                        end
`endif
                    end
                end
            endcase
        end
        m_wait = stalled ? m_wait + 1 : 0;
    endtask

    task automatic check(input string tag);
        checks++;
        assert (state === m_state) else begin
            failures++;
            $error("FAIL %s state got=%0h exp=%0h", tag, state, m_state);
        end
        checks++;
        assert (stack_level === LW'(m_stk.size())) else begin
            failures++;
            $error("FAIL %s stack_level got=%0d exp=%0d", tag, stack_level, m_stk.size());
        end
        checks++;
        assert (fault === m_fault) else begin
            failures++;
            $error("FAIL %s fault got=%0b exp=%0b", tag, fault, m_fault);
        end
        checks++;
        assert (err_code === m_err) else begin
            failures++;
            $error("FAIL %s err_code got=%0d exp=%0d", tag, err_code, m_err);
        end
    endtask

    task automatic step(input logic [1:0] c, input logic [SW-1:0] t, input logic [SW-1:0] r,
                        input logic rdy, input logic clr, input string tag);
        @(negedge clk);
        cmd       = c;
        tgt_state = t;
        ret_state = r;
        ready     = rdy;
        clr_fault = clr;
        @(posedge clk);
        model_step(c, t, r, rdy, clr);
        #1;
        check(tag);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        cmd       = CMD_NEXT;
        tgt_state = '0;
        ret_state = '0;
        ready     = 1'b0;
        clr_fault = 1'b0;
        model_reset();
        #3;
        check("reset");
        @(negedge clk);
        rst = 1'b0;

        step(CMD_NEXT, 8'h03, 8'h00, 1'b0, 1'b0, "next3");
        step(CMD_CALL, 8'h20, 8'h05, 1'b0, 1'b0, "call");
        step(CMD_RET,  8'h00, 8'h00, 1'b0, 1'b0, "ret");

        for (int i = 0; i < DEPTH; i++)
            step(CMD_CALL, 8'(8'h30 + i), 8'(8'h40 + i), 1'b0, 1'b0, "nest");
        step(CMD_CALL, 8'h77, 8'h66, 1'b0, 1'b0, "overflow");
        step(CMD_NEXT, 8'h12, 8'h00, 1'b0, 1'b0, "ovf_hold");
        step(CMD_NEXT, 8'h12, 8'h00, 1'b0, 1'b1, "clr_ovf");

        step(CMD_RET,  8'h00, 8'h00, 1'b0, 1'b0, "underflow");
        step(CMD_NEXT, 8'h55, 8'h00, 1'b0, 1'b0, "unf_ignore");
        step(CMD_CALL, 8'h56, 8'h57, 1'b0, 1'b0, "unf_no_ovf");
        step(CMD_NEXT, 8'h00, 8'h00, 1'b0, 1'b1, "clr_unf");

        for (int i = 0; i < 3; i++)
            step(CMD_WAIT, 8'h10, 8'h00, 1'b0, 1'b0, "wait_hold");
        step(CMD_WAIT, 8'h10, 8'h00, 1'b1, 1'b0, "wait_go");

        for (int i = 0; i < WDOG + 1; i++)
            step(CMD_WAIT, 8'h21, 8'h00, 1'b0, 1'b0, "wdog_stall");
        step(CMD_NEXT, 8'h00, 8'h00, 1'b0, 1'b1, "clr_wdog");
        for (int i = 0; i < WDOG - 1; i++)
            step(CMD_WAIT, 8'h22, 8'h00, 1'b0, 1'b0, "wdog_pre");
        step(CMD_WAIT, 8'h22, 8'h00, 1'b1, 1'b0, "wdog_ready_wins");

        step(CMD_CALL, 8'h60, 8'h61, 1'b0, 1'b0, "pre_rst_call");
        step(CMD_WAIT, 8'h62, 8'h00, 1'b0, 1'b0, "pre_rst_wait");
        step(CMD_WAIT, 8'h62, 8'h00, 1'b0, 1'b0, "pre_rst_wait");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_mid_wait");
        #1;
        rst = 1'b0;
        step(CMD_NEXT, 8'h09, 8'h00, 1'b0, 1'b0, "post_rst");

        for (int i = 0; i < 400; i++) begin
            logic [1:0]    c;
            logic [SW-1:0] t;
            logic [SW-1:0] r;
            logic          rdy;
            logic          clr;
            c   = 2'($urandom_range(0, 3));
            t   = 8'($urandom);
            r   = 8'($urandom);
            rdy = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 15) == 0);
            step(c, t, r, rdy, clr, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_useq.md
# cpu_useq

Parametrised micro-sequencer for the CPU control path. It registers the current micro-state and keeps a return-address stack of configurable depth, so the CPU decode logic can issue next, call, return and wait-for-ready commands. Stack overflow and underflow are detected and reported instead of silently corrupting the state. It sits between the CPU's combinational state decode, which drives `cmd` from `state`, and the motherboard handshake, which drives `ready`.

## Interface
- `STATE_WIDTH`, 8: width of a micro-state code.
- `STACK_DEPTH`, 8: number of return entries (≥1).
- `RESET_STATE`, 0: state after reset or fault clear.
- `FAULT_STATE`, 'hFF: state held while faulted.
- `WDOG_CYCLES`, 16: wait timeout in cycles (only with the watchdog compiled in).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `cmd`  in  2  0=NEXT, 1=CALL, 2=RET, 3=WAIT.
- `tgt_state`  in  STATE_WIDTH  destination for NEXT/CALL/WAIT.
- `ret_state`  in  STATE_WIDTH  return address pushed on CALL.
- `ready`  in  1  wait-release condition (bus/mobo done).
- `clr_fault`  in  1  leave fault.
- `state`  out  STATE_WIDTH  current micro-state (registered).
- `stack_level`  out  $clog2(STACK_DEPTH+1)  occupied entries.
- `fault`  out  1  sticky fault flag.
- `err_code`  out  2  0=none, 1=overflow, 2=underflow, 3=timeout.

## Operation
- Reset: `state`=RESET_STATE, `stack_level`=0, `fault`=0, `err_code`=0, watchdog counter=0. Stack storage is not reset; its contents are undefined until written.
- Each clock edge, priority is: `clr_fault` > faulted hold > `cmd`.
- `clr_fault`=1:
  - `state`←RESET_STATE, `stack_level`←0, `fault`←0, `err_code`←0.
  - Takes effect whether or not the block is faulted.
- Faulted hold (`fault`=1): `state` stays FAULT_STATE and `cmd` is ignored.
- NEXT: `state`←`tgt_state`.
- CALL:
  - Level < STACK_DEPTH: entry[level]←`ret_state`, level+1, `state`←`tgt_state`.
  - Level = STACK_DEPTH: overflow fault. `state`←FAULT_STATE, `fault`←1, `err_code`←1, stack unchanged.
- RET:
  - Level > 0: `state`←entry[level-1], level-1.
  - Level = 0: underflow fault, `err_code`←2.
- WAIT:
  - `ready`=1: `state`←`tgt_state`.
  - `ready`=0: `state` holds.
  - The stack is untouched in both cases.
- The first error is latched. `err_code` is not overwritten until `clr_fault`.
- Calls nest up to STACK_DEPTH. A call issued from inside a called routine pushes on top. The stack is a LIFO and never wraps.

## Timing
- `cmd`, `tgt_state`, `ret_state`, `ready` and `clr_fault` are sampled on the rising edge.
- `state`, `stack_level`, `fault` and `err_code` update on that same edge, so each command has one-cycle latency.
- The parent decodes `cmd` combinationally from `state`. One command executes per cycle.
- RET returns the pushed value on the following edge. A CALL then RET pair takes exactly 2 cycles.
- `rst` clears the block asynchronously, including mid-wait and mid-call sequences. The first edge after deassertion executes `cmd` normally.

## Configuration
- `USEQ_WATCHDOG_EN` defined:
  - A counter tracks consecutive cycles of WAIT with `ready`=0. It clears on any other cycle.
  - When the WDOG_CYCLES-th such cycle is sampled still not ready, a timeout fault is raised: `state`←FAULT_STATE, `err_code`←3.
  - `ready`=1 on that limit cycle wins, and no fault is raised.
- Not defined: WAIT may hold forever. `err_code`=3 is never produced and the counter is absent.

## Structure
- Package `cpu_useq_pkg`: `useq_cmd_t` enum (NEXT/CALL/RET/WAIT) and `useq_err_t` enum (NONE/OVF/UNF/TMO). The CPU decode logic shares it.
- Sub-module `cpu_useq_stack`: LIFO storage and level counter, with push/pop strobes, full/empty outputs and a top-of-stack read.
- The sequencer FSM, fault latch and watchdog live in `cpu_useq`.

## Test plan
- Reset then NEXT tgt=3 → `state`=3 after one edge, `stack_level`=0, `fault`=0.
- CALL tgt=0x20 ret=0x05, then RET → `state` 0x20 (level 1), then 0x05 (level 0).
- STACK_DEPTH=4: 4 nested CALLs, then a 5th → `fault`=1, `err_code`=1, `state`=0xFF, level 4. Next, `clr_fault` → `state`=0, level 0, `err_code`=0.
- RET at level 0 → `err_code`=2, `state`=0xFF. A following NEXT is ignored.
- WAIT tgt=0x10 with `ready` low for 3 cycles, then high → `state` holds 3 cycles, then becomes 0x10.
- With `USEQ_WATCHDOG_EN` and WDOG_CYCLES=16:
  - 16 cycles of WAIT with `ready`=0 → `err_code`=3.
  - `ready` rising on cycle 16 → no fault, `state`=tgt.
  - `rst` pulsed mid-wait → all outputs return to reset values immediately.
